// File: rtl/cmd_controller_v2.sv
// Framed-command controller: UART byte frames (OP, LEN, payload, XOR CSUM) to RoC control registers, one status response per frame.
// Response OP byte is valid two cycles after the checksum byte; each response byte is held until the tx handshake.
module cmd_controller_v2 #(
    parameter int ROC_INPUTS     = 64,
    parameter int ROC_OUTPUTS    = 64,
    parameter int OUT_BYTES      = (ROC_OUTPUTS + 7) / 8,
    parameter int MAX_PAYLOAD    = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_rx_valid,
    input  logic [7:0]             i_rx_data,
    output logic                   o_tx_valid,
    output logic [7:0]             o_tx_data,
    input  logic                   i_tx_ready,
    input  logic [ROC_OUTPUTS-1:0] i_roc_outputs,
    output logic [ROC_INPUTS-1:0]  o_roc_inputs,
    output logic [31:0]            o_roc_tps,
    output logic                   o_roc_en,
    output logic                   o_busy,
    output logic [15:0]            o_err_count
);
    localparam int          SW   = 8 * OUT_BYTES;
    localparam int          IW   = (ROC_INPUTS > 1) ? $clog2(ROC_INPUTS) : 1;
    localparam int          TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] MAXP = MAX_PAYLOAD;
    localparam logic [31:0] NIN  = ROC_INPUTS;

    typedef enum logic [3:0] {
        S_IDLE, S_LEN, S_PAYLOAD, S_DRAIN, S_CSUM, S_EXEC,
        S_RESP_OP, S_RESP_STATUS, S_RESP_DATA, S_RESP_CSUM
    } state_t;

    state_t         state;
    logic [7:0]     op, len, cnt, xr, status, rcs;
    logic [31:0]    pbuf;
    logic [SW-1:0]  snap, out_sh;
    logic [TW-1:0]  tcnt;

    logic           known, in_frame, timeout, drop, err_event, tx_fire;
    logic [7:0]     exp_len, chk_status;

    assign o_busy = (state != S_IDLE);

    always_comb begin
        known   = 1'b1;
        exp_len = 8'd0;
        case (op)
            8'hC0, 8'hC1, 8'hC2, 8'hC3: exp_len = 8'd0;
            8'hC4, 8'hC5:               exp_len = 8'd4;
            8'hC6:                      exp_len = 8'd1;
            default:                    known   = 1'b0;
        endcase
    end

    // Every valid command carries at most 4 payload bytes, so the last four received are all EXEC ever reads.
    always_comb begin
        chk_status = 8'h00;
        if (xr != i_rx_data)
            chk_status = 8'h01;
        else if (!known)
            chk_status = 8'h03;
        else if (len != exp_len)
            chk_status = 8'h02;
        else if (op == 8'hC4 && {8'd0, pbuf[31:8]} >= NIN)
            chk_status = 8'h04;
    end

    assign in_frame  = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM) || (state == S_DRAIN);
    assign timeout   = in_frame && !i_rx_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign drop      = i_rx_valid && (state == S_EXEC || state == S_RESP_OP || state == S_RESP_STATUS ||
                                      state == S_RESP_DATA || state == S_RESP_CSUM);
    assign err_event = drop || timeout || (state == S_EXEC && status != 8'h00);
    assign tx_fire   = o_tx_valid && i_tx_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            op           <= '0;
            len          <= '0;
            cnt          <= '0;
            xr           <= '0;
            status       <= '0;
            rcs          <= '0;
            pbuf         <= '0;
            snap         <= '0;
            out_sh       <= '0;
            tcnt         <= '0;
            o_tx_valid   <= 1'b0;
            o_tx_data    <= '0;
            o_roc_inputs <= '0;
            o_roc_tps    <= '0;
            o_roc_en     <= 1'b0;
            o_err_count  <= '0;
        end else begin
            if (err_event && o_err_count != 16'hFFFF)
                o_err_count <= o_err_count + 16'd1;
            if (in_frame)
                tcnt <= i_rx_valid ? '0 : tcnt + TW'(1);

            if (timeout) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (i_rx_valid) begin
                        op    <= i_rx_data;
                        xr    <= i_rx_data;
                        tcnt  <= '0;
                        state <= S_LEN;
                    end
                    S_LEN: if (i_rx_valid) begin
                        len <= i_rx_data;
                        xr  <= xr ^ i_rx_data;
                        cnt <= '0;
                        if (i_rx_data == 8'd0)
                            state <= S_CSUM;
                        else if ({24'd0, i_rx_data} <= MAXP)
                            state <= S_PAYLOAD;
                        else
                            state <= S_DRAIN;
                    end
                    S_PAYLOAD: if (i_rx_valid) begin
                        pbuf <= {pbuf[23:0], i_rx_data};
                        xr   <= xr ^ i_rx_data;
                        cnt  <= cnt + 8'd1;
                        if (cnt == len - 8'd1)
                            state <= S_CSUM;
                    end
                    S_DRAIN: if (i_rx_valid) begin
                        cnt <= cnt + 8'd1;
                        if (cnt == len) begin
                            status <= 8'h02;
                            state  <= S_EXEC;
                        end
                    end
                    S_CSUM: if (i_rx_valid) begin
                        status <= chk_status;
                        state  <= S_EXEC;
                    end
                    S_EXEC: begin
                        if (status == 8'h00) begin
                            case (op)
                                8'hC0: begin
                                    o_roc_inputs <= '0;
                                    o_roc_tps    <= '0;
                                    o_roc_en     <= 1'b0;
                                    snap         <= '0;
                                end
                                8'hC3: snap <= SW'(i_roc_outputs);
                                8'hC4: o_roc_inputs[pbuf[8 +: IW]] <= pbuf[0];
                                8'hC5: o_roc_tps <= pbuf;
                                8'hC6: o_roc_en  <= pbuf[0];
                                default: ;
                            endcase
                        end
                        out_sh     <= snap;
                        rcs        <= '0;
                        o_tx_valid <= 1'b1;
                        o_tx_data  <= op;
                        state      <= S_RESP_OP;
                    end
                    S_RESP_OP: if (tx_fire) begin
                        rcs       <= rcs ^ o_tx_data;
                        o_tx_data <= status;
                        state     <= S_RESP_STATUS;
                    end
                    S_RESP_STATUS: if (tx_fire) begin
                        rcs <= rcs ^ o_tx_data;
                        if (status == 8'h00 && op == 8'hC2) begin
                            o_tx_data <= out_sh[7:0];
                            out_sh    <= out_sh >> 8;
                            cnt       <= '0;
                            state     <= S_RESP_DATA;
                        end else begin
                            o_tx_data <= rcs ^ o_tx_data;
                            state     <= S_RESP_CSUM;
                        end
                    end
                    S_RESP_DATA: if (tx_fire) begin
                        rcs <= rcs ^ o_tx_data;
                        if (cnt == 8'(OUT_BYTES - 1)) begin
                            o_tx_data <= rcs ^ o_tx_data;
                            state     <= S_RESP_CSUM;
                        end else begin
                            o_tx_data <= out_sh[7:0];
                            out_sh    <= out_sh >> 8;
                            cnt       <= cnt + 8'd1;
                        end
                    end
                    S_RESP_CSUM: if (tx_fire) begin
                        o_tx_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/cmd_controller_v2.md
Name: cmd_controller_v2

Overview:
- Parametrised framed-command controller between a byte-stream UART link and the RoC core.
- Replaces fixed 6-byte commands with variable-length frames (opcode, length, payload, XOR checksum).
- Every frame returns a status response; the block adds error detection, timeouts and an error counter.
- Byte-level valid/ready interfaces only; UART rx/tx instances live outside this block.

Parameters:
- ROC_INPUTS, 64, number of RoC input bits driven by o_roc_inputs.
- ROC_OUTPUTS, 64, number of RoC output bits sampled from i_roc_outputs.
- OUT_BYTES, ceil(ROC_OUTPUTS/8), bytes returned by GET_OUTPUTS; upper bits zero-padded.
- MAX_PAYLOAD, 8, largest stored payload in bytes (must be >= 4).
- TIMEOUT_CYCLES, 100000, idle clocks allowed between bytes inside a frame.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- i_rx_data  in  8  received byte
- o_tx_valid  out  1  response byte valid; held until accepted
- o_tx_data  out  8  response byte; stable while o_tx_valid=1
- i_tx_ready  in  1  transmitter accepts byte when o_tx_valid & i_tx_ready
- i_roc_outputs  in  ROC_OUTPUTS  live RoC outputs
- o_roc_inputs  out  ROC_INPUTS  RoC input register
- o_roc_tps  out  32  target ticks-per-second
- o_roc_en  out  1  RoC run enable
- o_busy  out  1  high whenever state != IDLE
- o_err_count  out  16  saturating count of rejected or aborted frames

Behaviour:
- Reset (async assert, sync release): state IDLE; o_tx_valid=0, o_tx_data=0, o_roc_inputs=0, o_roc_tps=0, o_roc_en=0, o_err_count=0, snapshot register=0.
- Frame format: OP, LEN, LEN payload bytes, CSUM, where CSUM = XOR of OP, LEN and all payload bytes.
- Response format: OP, STATUS, data bytes (GET_OUTPUTS with STATUS=0 only), RCSUM, where RCSUM = XOR of all preceding response bytes.
- STATUS codes: 00 OK, 01 CSUM, 02 LEN, 03 OPCODE, 04 RANGE.
- States:
  - IDLE: rx byte -> store OP, go to LEN.
  - LEN: store LEN. LEN=0 -> CSUM. LEN<=MAX_PAYLOAD -> PAYLOAD. LEN>MAX_PAYLOAD -> DRAIN.
  - PAYLOAD: store bytes into the payload buffer in arrival order; after byte LEN -> CSUM.
  - DRAIN: discard LEN payload bytes and the checksum byte, then go to EXEC with STATUS=02.
  - CSUM: compare against the running XOR -> EXEC.
  - EXEC: one cycle; apply the command only if STATUS=00.
  - RESP_OP, RESP_STATUS, RESP_DATA, RESP_CSUM: one byte each, each advancing on the tx handshake. After RESP_CSUM -> IDLE.
- Status priority: LEN-oversize > CSUM > OPCODE > LEN-mismatch > RANGE.
- Commands (payload multi-byte fields are big-endian):
  - C0 RESET: LEN=0; clears inputs, tps, en and the snapshot register.
  - C1 PING: LEN=0.
  - C2 GET_OUTPUTS: LEN=0; response data is the snapshot register, OUT_BYTES bytes, LSB byte first.
  - C3 CAPTURE: LEN=0; snapshot <= i_roc_outputs sampled in the EXEC cycle.
  - C4 SET_INPUT: LEN=4; index = payload[0..2] (24 bit); bit = payload[3][0]; index>=ROC_INPUTS -> RANGE, no write.
  - C5 SET_TPS: LEN=4.
  - C6 SET_EN: LEN=1; en = payload[0][0].
  - Any other OP -> OPCODE.
  - A wrong LEN for a known opcode -> LEN (mismatch).
- Latency: the checksum byte is accepted at cycle t; EXEC runs at t+1; o_tx_valid=1 carrying OP at t+2. Side effects are visible at the outputs at t+2.
- Timeout: in LEN, PAYLOAD, CSUM or DRAIN, a counter reloads on each rx byte. If TIMEOUT_CYCLES clocks pass with no byte: abort silently (no response), go to IDLE, increment o_err_count.
- rx bytes arriving during EXEC or RESP_*: dropped and o_err_count incremented. Frame state is unaffected.
- o_err_count increments on every STATUS!=00 frame, every timeout, and every dropped byte. It holds at FFFF. A same-cycle double event counts once.
- Reset asserted mid-frame or mid-response: immediate return to reset values. A partial response is not resumed.

Test Plan:
- PING: rx C1,00,C1 -> tx C1,00,C1; o_err_count stays 0; o_tx_valid rises exactly 2 cycles after the last rx strobe.
- SET_INPUT then readback (ROC_INPUTS=64): rx C4,04,00,00,05,01,CSUM=C4 -> tx C4,00,C4; o_roc_inputs[5]=1. Then with i_roc_outputs=64'h0123456789ABCDEF, send CAPTURE then GET_OUTPUTS -> data bytes EF,CD,AB,89,67,45,23,01 and correct RCSUM.
- Error codes:
  - Bad checksum C5,04,00,00,03,E8,00 -> tx C5,01,C4; o_roc_tps unchanged; o_err_count=1.
  - OP=D0 with a valid CSUM -> STATUS 03.
  - SET_INPUT with index 64 -> STATUS 04 and o_roc_inputs unchanged.
- Oversize: rx C1,0A, ten bytes, checksum byte -> all bytes drained, response C1,02,C3; no byte is taken as a new frame.
- Timeout plus backpressure:
  - rx C5,04,00 then silence for TIMEOUT_CYCLES -> no tx, state IDLE, o_err_count+1.
  - With i_tx_ready held low for 50 cycles, o_tx_valid and o_tx_data stay constant until ready.
- Async reset asserted during RESP_DATA of GET_OUTPUTS -> o_tx_valid=0 immediately; all outputs at reset values; a following PING is answered normally.
